// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential WIDTHxWIDTH multiplier between two requesters.
//   Round-robin grant, operand latch, one-cycle start pulse, rising-edge
//   completion detect, product capture and a one-cycle ack to the winner.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req0/a0/b0          : requester 0 request (held until ack0) and operands
//   req1/a1/b1          : requester 1 request (held until ack1) and operands
//   ack0, ack1          : one-cycle result-valid pulses
//   rsp_product         : captured product, held until the next capture
//   busy                : high whenever the FSM is not IDLE
//   grant_id            : current / last granted requester (resets to 1)
//   mul_start/a/b       : start pulse and latched operands to the multiplier
//   mul_product/done    : multiplier result and done level
//   err                 : watchdog timeout pulse
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT_CYCLES cycles. Without it err is tied low and WAIT never expires.
module mult_share_arbiter #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               busy,
  output logic               grant_id,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic   done_q;
  logic   done_edge;
  logic   gnt_fire;
  logic   gnt_sel;
  logic   timeout_hit;

  // A held-high done level from a previous operation must not count.
  assign done_edge = mul_done & ~done_q;

  assign busy      = (state != IDLE);
  assign mul_start = (state == START);
  assign ack0      = (state == RESP) & ~grant_id;
  assign ack1      = (state == RESP) &  grant_id;

  always_comb begin
    state_nx = state;
    gnt_fire = 1'b0;
    gnt_sel  = grant_id;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_fire = 1'b1;
          // Both pending: the one not served last wins; else the lone one.
          gnt_sel  = (req0 & req1) ? ~grant_id : req1;
          state_nx = START;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (done_edge)        state_nx = RESP;
        else if (timeout_hit) state_nx = IDLE;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      grant_id    <= 1'b1;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
    end else begin
      state  <= state_nx;
      done_q <= mul_done;
      if (gnt_fire) begin
        grant_id <= gnt_sel;
        mul_a    <= gnt_sel ? a1 : a0;
        mul_b    <= gnt_sel ? b1 : b0;
      end
      if (state == WAIT && done_edge)
        rsp_product <= mul_product;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // to_cnt is 0 on the first WAIT cycle; the last allowed WAIT cycle is
  // TIMEOUT_CYCLES-1, so err is seen TIMEOUT_CYCLES cycles after entry.
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= (state == WAIT) & ~done_edge & timeout_hit;
      to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1, busy, grant_id, mul_start, err;
  logic [15:0] rsp_product;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_product = '0;
  logic        mul_done = 1'b0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .rsp_product(rsp_product),
    .busy(busy), .grant_id(grant_id),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done), .err(err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sequential multiplier model: done level rises dly cycles after start.
  // stale: keep the old done level high for 2 cycles after start.
  // never: done never rises.
  int m_cnt = 0;
  bit m_busy = 0;
  int dly = 8;
  bit stale = 0, never = 0;

  always @(posedge clk) begin
    if (reset) begin
      mul_done <= 1'b0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
    end else if (mul_start) begin
      mul_product <= 16'(mul_a) * 16'(mul_b);
      m_cnt       <= 1;
      m_busy      <= 1'b1;
      if (!stale) mul_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (stale && m_cnt == 2) mul_done <= 1'b0;
      if (!never && m_cnt == dly) begin
        mul_done <= 1'b1;
        m_busy   <= 1'b0;
      end
    end
  end

  // Scoreboard
  typedef struct { bit id; logic [15:0] p; } exp_t;
  exp_t exp_q[$];
  int start_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, err_cnt = 0;

  task automatic push(input bit id, input logic [15:0] p);
    exp_t e;
    e.id = id; e.p = p;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mul_start) start_cnt++;
    if (err) err_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (ack0 || ack1) begin
      chk("ack_onehot", ack0 & ack1, 0);
      if (exp_q.size() == 0) chk("ack_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("ack_id", ack1, e.id);
        chk("ack_prod", rsp_product, e.p);
      end
    end
  end

  // which: 0 = mul_start, 1 = any ack, 2 = err
  task automatic wait_for(input int which, input string tag, output int n);
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = mul_start;
        1:       hit = ack0 | ack1;
        default: hit = err;
      endcase
    end
    chk({tag, "_seen"}, hit, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_start"}, mul_start, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rsp"}, rsp_product, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_grant"}, grant_id, 1);
  endtask

  initial begin
    int n, s0, k0, k1;
    reset = 1'b1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Single request
    a0 = 8'd12; b0 = 8'd13; req0 = 1;
    push(0, 16'd156);
    s0 = start_cnt; k0 = ack0_cnt; k1 = ack1_cnt;
    wait_for(0, "single_start", n);
    chk("single_start_lat", n, 1);
    chk("single_mul_a", mul_a, 12);
    chk("single_mul_b", mul_b, 13);
    chk("single_grant", grant_id, 0);
    wait_for(1, "single_ack", n);
    chk("single_ack_lat", n, 10);
    chk("single_ack0", ack0, 1);
    req0 = 0;
    repeat (3) @(negedge clk);
    chk("single_one_start", start_cnt - s0, 1);
    chk("single_one_ack0", ack0_cnt - k0, 1);
    chk("single_no_ack1", ack1_cnt - k1, 0);
    chk("single_rsp_held", rsp_product, 156);
    chk("single_idle", busy, 0);

    // Simultaneous requests, two rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a0 = 8'd3; b0 = 8'd5; a1 = 8'd255; b1 = 8'd255;
      req0 = 1; req1 = 1;
      push(0, 16'd15);
      push(1, 16'hFE01);
      wait_for(1, "both_first", n);
      chk("both_first_is_0", ack0, 1);
      req0 = 0;
      wait_for(1, "both_second", n);
      chk("both_second_is_1", ack1, 1);
      chk("both_second_gap", n, 12);
      req1 = 0;
      @(negedge clk);
    end

    // Stale done level from the previous op
    stale = 1; dly = 6;
    a0 = 8'd20; b0 = 8'd11; req0 = 1;
    push(0, 16'd220);
    wait_for(0, "stale_start", n);
    wait_for(1, "stale_ack", n);
    chk("stale_ack_lat", n, 8);
    req0 = 0;
    stale = 0; dly = 8;
    @(negedge clk);

    // Operand change and request drop after grant
    a0 = 8'd7; b0 = 8'd9; req0 = 1;
    push(0, 16'd63);
    wait_for(0, "drop_start", n);
    a0 = 8'd200; b0 = 8'd1; req0 = 0;
    wait_for(1, "drop_ack", n);
    chk("drop_ack0", ack0, 1);
    chk("drop_ack_lat", n, 10);
    repeat (2) @(negedge clk);
    chk("drop_mul_a_held", mul_a, 7);
    chk("drop_mul_b_held", mul_b, 9);

    // Reset in WAIT
    a1 = 8'd10; b1 = 8'd10; req1 = 1;
    wait_for(0, "mid_start", n);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    k0 = ack0_cnt; k1 = ack1_cnt; s0 = start_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid");
    reset = 1'b0; req1 = 0;
    repeat (12) @(negedge clk);
    chk("mid_no_ack", (ack0_cnt - k0) + (ack1_cnt - k1), 0);
    chk("mid_no_start", start_cnt - s0, 0);
    a0 = 8'd2; b0 = 8'd100; a1 = 8'd16; b1 = 8'd16;
    req0 = 1; req1 = 1;
    push(0, 16'd200);
    push(1, 16'd256);
    wait_for(1, "post_first", n);
    chk("post_first_is_0", ack0, 1);
    req0 = 0;
    wait_for(1, "post_second", n);
    chk("post_second_is_1", ack1, 1);
    req1 = 0;
    @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
    never = 1;
    k0 = ack0_cnt; k1 = ack1_cnt;
    a0 = 8'd1; b0 = 8'd1; req0 = 1;
    wait_for(0, "to_start", n);
    wait_for(2, "to_err", n);
    chk("to_err_after_wait_entry", n - 1, 16);
    chk("to_busy_drop", busy, 0);
    req0 = 0;
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    chk("to_no_ack", (ack0_cnt - k0) + (ack1_cnt - k1), 0);
    chk("to_rsp_kept", rsp_product, 256);
    never = 0;
`else
    chk("err_tied_low", err_cnt, 0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
